prog_loader: RTL and testbench
==============================

# prog_loader

Upstream boot stage for the multicycle CPU. Accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words and writes them into instruction memory through a dedicated write port. It holds the CPU in reset while loading and supplies the CPU's initial PC (`init`). The CPU is released only after a length-checked, XOR-checksummed image has been fully written.

## Interface
- `ADDR_W`, default 8: instruction memory word-address width; capacity is 2^ADDR_W words.
- `INIT_PC`, default 32'h0: value driven on `cpu_init`.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begins a load session; single-cycle pulse is sufficient.
- `rx_valid` in 1: input byte valid.
- `rx_data` in 8: input byte.
- `rx_ready` out 1: loader can accept a byte.
- `im_we` out 1: instruction memory write strobe, one cycle per word.
- `im_addr` out 32: byte address of the write, always word-aligned.
- `im_wdata` out 32: instruction word.
- `cpu_reset` out 1: drives the CPU `reset`.
- `cpu_init` out 32: drives the CPU `init`; constant `INIT_PC`.
- `busy` out 1: a session is in progress.
- `done` out 1: last session succeeded.
- `err` out 1: last session failed.

## Operation
- Stream format: count N as 2 bytes, big-endian, 16 bits; then N×4 data bytes, each word MSB first; then 1 checksum byte.
- Checksum: XOR of every header and data byte. Valid when the received checksum equals this XOR.
- States and transitions:
  - IDLE: `start` -> HDR_HI.
  - HDR_HI: on a byte -> HDR_LO.
  - HDR_LO: on a byte, N==0 -> CSUM; N>2^ADDR_W -> ERR; otherwise -> DATA.
  - DATA: after the 4N-th byte -> CSUM.
  - CSUM: on a byte, match -> RUN; mismatch -> ERR.
  - RUN and ERR: `start` -> HDR_HI.
- A byte transfers when `rx_valid && rx_ready` at a rising edge.
- `rx_ready` is 1 in HDR_HI, HDR_LO, DATA and CSUM. It is 0 in IDLE, RUN and ERR.
- `start` is ignored while `busy`=1.
- Entering HDR_HI does the following:
  - clears `done` and `err` and the checksum accumulator;
  - resets the word index and byte counter to 0;
  - sets `busy`=1 and `cpu_reset`=1.
- Word assembly: byte k of a word (k = 0..3) goes to bits [31-8k -: 8].
- When byte 3 is accepted, the word index w is latched. `im_addr` = {w,2'b00} zero-extended to 32 bits, and w then increments.
- Memory writes are not rolled back on checksum failure. ERR keeps `cpu_reset`=1, so the image is never executed.
- Outputs per state:
  - `busy`=1 in HDR_HI through CSUM.
  - `done`=1 only in RUN.
  - `err`=1 only in ERR.
  - `cpu_reset`=0 only in RUN.

## Timing
- Reset values:
  - state IDLE;
  - `rx_ready`=0, `im_we`=0, `im_addr`=0, `im_wdata`=0;
  - `busy`=0, `done`=0, `err`=0;
  - `cpu_reset`=1, `cpu_init`=`INIT_PC`.
- Reset mid-session: the next cycle is IDLE with the reset values above. Any partial word is discarded and no `im_we` is issued for it.
- `start` sampled at edge t: `rx_ready`=1 and `busy`=1 from cycle t+1.
- The 4th byte of a word accepted at edge t: `im_we`=1 with valid `im_addr`/`im_wdata` during cycle t+1 only. `im_addr`/`im_wdata` hold until the next write.
- Back-to-back bytes (`rx_valid` held high) are accepted at 1 byte/cycle with no bubbles. `im_we` pulses are at least 4 cycles apart.
- Checksum byte accepted at edge t: `done`=1 or `err`=1 from cycle t+1.
  - On success, `cpu_reset` falls in the same cycle t+1.
  - The final `im_we` always precedes the checksum byte, so memory is complete before the CPU is released.
- Oversize N: ERR from the cycle after the HDR_LO byte. No `im_we` is issued.
- `start` and `reset` asserted together: `reset` wins.
- `rx_valid` with `rx_ready`=0: the byte is ignored and no state change occurs.

## Test plan
- Reset with `ADDR_W`=8, `INIT_PC`=0: check `cpu_reset`=1, `rx_ready`=0, `busy`/`done`/`err`=0, `cpu_init`=0. Then `rx_valid`=1 in IDLE -> no state change.
- `start`, then bytes 00 02 20 01 00 05 00 00 00 00 26 back-to-back:
  - `im_we` at addr 0, data 32'h20010005;
  - `im_we` at addr 4, data 32'h00000000;
  - one cycle after byte 0x26: `done`=1, `cpu_reset`=0, `busy`=0.
- Same stream with checksum 0x27 -> `err`=1, `done`=0, `cpu_reset` stays 1. Then a `start` plus the correct stream -> `done`=1.
- N=0: bytes 00 00 00 -> no `im_we`, `done`=1. N=0x0101 -> `err`=1 one cycle after the 2nd byte, `rx_ready`=0, no writes.
- Random `rx_valid` gaps (1–3 idle cycles) on the first stream -> identical writes and result. Also check that `start` pulsed mid-DATA has no effect.
- `reset` asserted after 6 of 8 data bytes -> IDLE next cycle, `cpu_reset`=1, no further `im_we`. A new full session completes normally.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader: boot-time byte-stream loader for instruction memory.
// Holds the CPU in reset until a length- and XOR-checked image is written.
module prog_loader #(
    parameter int          ADDR_W  = 8,
    parameter logic [31:0] INIT_PC = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        im_we,
    output logic [31:0] im_addr,
    output logic [31:0] im_wdata,
    output logic        cpu_reset,
    output logic [31:0] cpu_init,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR_HI, S_HDR_LO, S_DATA, S_CSUM, S_RUN, S_ERR
    } state_t;

    state_t              state_q, state_d;
    logic [15:0]         n_q, n_d;
    logic [7:0]          csum_q, csum_d;
    logic [23:0]         wbuf_q, wbuf_d;
    logic [1:0]          bcnt_q, bcnt_d;
    logic [ADDR_W:0]     widx_q, widx_d;
    logic                we_q, we_d;
    logic [31:0]         addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;

    logic                xfer;
    logic [ADDR_W:0]     widx_nxt;
    logic [16:0]         n_full;
    logic [16:0]         cap;

    assign xfer     = rx_valid && rx_ready;
    assign widx_nxt = widx_q + 1'b1;
    assign n_full   = {1'b0, n_q[15:8], rx_data};
    assign cap      = 17'd1 << ADDR_W;

    // Status outputs are a pure function of the session state
    always_comb begin
        rx_ready  = (state_q == S_HDR_HI) || (state_q == S_HDR_LO) ||
                    (state_q == S_DATA)   || (state_q == S_CSUM);
        busy      = rx_ready;
        done      = (state_q == S_RUN);
        err       = (state_q == S_ERR);
        cpu_reset = (state_q != S_RUN);
        cpu_init  = INIT_PC;
        im_we     = we_q;
        im_addr   = addr_q;
        im_wdata  = wdata_q;
    end

    // Next-state: header parse, word assembly and checksum decision
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        csum_d  = csum_q;
        wbuf_d  = wbuf_q;
        bcnt_d  = bcnt_q;
        widx_d  = widx_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            S_IDLE, S_RUN, S_ERR: begin
                if (start) begin
                    state_d = S_HDR_HI;
                    csum_d  = 8'h00;
                    bcnt_d  = 2'd0;
                    widx_d  = '0;
                end
            end
            S_HDR_HI: begin
                if (xfer) begin
                    n_d[15:8] = rx_data;
                    csum_d    = csum_q ^ rx_data;
                    state_d   = S_HDR_LO;
                end
            end
            S_HDR_LO: begin
                if (xfer) begin
                    n_d[7:0] = rx_data;
                    csum_d   = csum_q ^ rx_data;
                    if (n_full == 17'd0)
                        state_d = S_CSUM;
                    else if (n_full > cap)
                        state_d = S_ERR;
                    else
                        state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (xfer) begin
                    csum_d = csum_q ^ rx_data;
                    bcnt_d = bcnt_q + 2'd1;
                    unique case (bcnt_q)
                        2'd0: wbuf_d[23:16] = rx_data;
                        2'd1: wbuf_d[15:8]  = rx_data;
                        2'd2: wbuf_d[7:0]   = rx_data;
                        default: begin
                            we_d    = 1'b1;
                            wdata_d = {wbuf_q, rx_data};
                            addr_d  = 32'({widx_q[ADDR_W-1:0], 2'b00});
                            widx_d  = widx_nxt;
                            if (17'(widx_nxt) == {1'b0, n_q})
                                state_d = S_CSUM;
                        end
                    endcase
                end
            end
            S_CSUM: begin
                if (xfer)
                    state_d = (rx_data == csum_q) ? S_RUN : S_ERR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            csum_q  <= '0;
            wbuf_q  <= '0;
            bcnt_q  <= '0;
            widx_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            csum_q  <= csum_d;
            wbuf_q  <= wbuf_d;
            bcnt_q  <= bcnt_d;
            widx_q  <= widx_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed stream sessions against a stream-level model.
// Expected writes and outcome are derived from the byte list itself.
module tb_prog_loader;

    localparam int AW = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready, im_we, cpu_reset, busy, done, err;
    logic [31:0] im_addr, im_wdata, cpu_init;

    int total = 0;
    int bad = 0;

    // phase: 0 idle/reset, 1 loading, 2 run, 3 error
    int          phase = 0;
    logic [63:0] exp_q[$];
    logic [7:0]  stream[$];
    int          m_stop;
    bit          m_ok;
    int          wcount = 0;
    logic [31:0] last_addr = 0;
    logic [31:0] last_data = 0;

    prog_loader #(.ADDR_W(AW), .INIT_PC(32'h0)) dut (
        .clk(clk), .reset(reset), .start(start),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
        .cpu_reset(cpu_reset), .cpu_init(cpu_init),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    // Stream model: parse header, list the writes, judge the checksum
    function automatic void model();
        int n;
        logic [7:0] x;
        logic [31:0] w;
        n = {stream[0], stream[1]};
        x = stream[0] ^ stream[1];
        if (n > (1 << AW)) begin
            m_stop = 1;
            m_ok = 0;
            return;
        end
        for (int i = 0; i < n; i++) begin
            w = 0;
            for (int k = 0; k < 4; k++) begin
                w = (w << 8) | 32'(stream[2 + 4*i + k]);
                x ^= stream[2 + 4*i + k];
            end
            exp_q.push_back({32'(4*i), w});
        end
        m_stop = 2 + 4*n;
        m_ok = (stream[m_stop] == x);
    endfunction

    // Per-cycle compare against the model's phase and write list
    always @(negedge clk) begin
        logic [63:0] e;
        chk("busy", busy, phase == 1);
        chk("rx_ready", rx_ready, phase == 1);
        chk("done", done, phase == 2);
        chk("err", err, phase == 3);
        chk("cpu_reset", cpu_reset, phase != 2);
        chk("cpu_init", cpu_init, 0);
        if (im_we) begin
            wcount++;
            last_addr = im_addr;
            last_data = im_wdata;
            if (exp_q.size() == 0) begin
                chk("spurious_we", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("we_addr", im_addr, e[63:32]);
                chk("we_data", im_wdata, e[31:0]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic session(input bit gaps, input int start_at);
        model();
        start = 1'b1;
        tick();
        start = 1'b0;
        phase = 1;
        for (int i = 0; i <= m_stop; i++) begin
            if (gaps) repeat ($urandom_range(1, 3)) tick();
            rx_valid = 1'b1;
            rx_data  = stream[i];
            start    = (i == start_at);
            tick();
            rx_valid = 1'b0;
            start    = 1'b0;
        end
        phase = m_ok ? 2 : 3;
        repeat (3) tick();
        chk("writes_left", 64'(exp_q.size()), 0);
        exp_q.delete();
    endtask

    initial begin
        repeat (2) tick();
        reset = 1'b0;
        tick();
        chk("init_reset_cpu", cpu_reset, 1);
        chk("init_ready", rx_ready, 0);

        rx_valid = 1'b1;
        rx_data  = 8'h00;
        repeat (3) tick();
        rx_valid = 1'b0;

        stream = '{8'h00, 8'h02, 8'h20, 8'h01, 8'h00, 8'h05,
                   8'h00, 8'h00, 8'h00, 8'h00, 8'h26};
        model();
        chk("model_w0", exp_q[0], {32'h0, 32'h20010005});
        chk("model_w1", exp_q[1], {32'h4, 32'h00000000});
        chk("model_ok", m_ok, 1);
        exp_q.delete();
        wcount = 0;
        session(0, -1);
        chk("n_writes", wcount, 2);
        chk("last_addr", last_addr, 32'h4);
        chk("last_data", last_data, 32'h0);
        chk("done_lit", done, 1);

        stream[10] = 8'h27;
        session(0, -1);
        chk("err_lit", err, 1);
        chk("err_cpu_reset", cpu_reset, 1);
        stream[10] = 8'h26;
        session(0, -1);
        chk("recover_done", done, 1);

        stream = '{8'h00, 8'h00, 8'h00};
        wcount = 0;
        session(0, -1);
        chk("n0_writes", wcount, 0);
        chk("n0_done", done, 1);

        stream = '{8'h01, 8'h01};
        session(0, -1);
        chk("big_writes", wcount, 0);
        chk("big_err", err, 1);

        stream = '{8'h00, 8'h02, 8'h20, 8'h01, 8'h00, 8'h05,
                   8'h00, 8'h00, 8'h00, 8'h00, 8'h26};
        wcount = 0;
        session(1, 7);
        chk("gap_writes", wcount, 2);
        chk("gap_done", done, 1);

        exp_q.push_back({32'h0, 32'h20010005});
        wcount = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        phase = 1;
        for (int i = 0; i < 8; i++) begin
            rx_valid = 1'b1;
            rx_data  = stream[i];
            tick();
        end
        rx_valid = 1'b0;
        reset = 1'b1;
        start = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        phase = 0;
        repeat (4) tick();
        chk("rst_writes", wcount, 1);
        chk("rst_cpu_reset", cpu_reset, 1);
        chk("rst_addr", im_addr, 0);
        session(0, -1);
        chk("after_rst_done", done, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
